// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, with a fast path for
// divide-by-zero and signed overflow. Stalls the pipeline while busy.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              a_neg_q, a_neg_d;
    logic              fast_q, fast_d;
    logic [XLEN-1:0]   fast_val_q, fast_val_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [2*XLEN:0]   rq_q, rq_d;      // {remainder[XLEN:0], quotient[XLEN-1:0]}
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed, a_neg_in, b_neg_in, is_fast;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift, div_diff;
    logic [XLEN-1:0]   quot, rem, prod_hi, res_fix;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_in = a_signed && a[XLEN-1];
        b_neg_in = b_signed && b[XLEN-1];
        a_mag_in = a_neg_in ? (~a + XLEN'(1)) : a;
        b_mag_in = b_neg_in ? (~b + XLEN'(1)) : b;
        is_fast  = op[2] && ((b == '0) ||
                   (!op[0] && (a == INT_MIN) && (b == '1)));

        // Shift-add: add multiplicand to the high half when the multiplier LSB is set.
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);

        // Restoring step; the extra top bit makes the borrow visible as a sign.
        div_shift = {rq_q[2*XLEN:XLEN], rq_q[XLEN-1]};
        div_diff  = div_shift - {2'b00, b_mag_q};

        quot = rq_q[XLEN-1:0];
        rem  = rq_q[2*XLEN-1:XLEN];
        // High half of the negated product: ~hi plus the carry out of (~lo + 1).
        prod_hi = neg_q ? (~prod_q[2*XLEN-1:XLEN] + XLEN'(prod_q[XLEN-1:0] == '0))
                        : prod_q[2*XLEN-1:XLEN];

        res_fix = '0;
        if (fast_q) begin
            res_fix = fast_val_q;
        end else begin
            case (op_q)
                OP_MUL:                       res_fix = prod_q[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: res_fix = prod_hi;
                OP_DIV, OP_DIVU:              res_fix = neg_q ? (~quot + XLEN'(1)) : quot;
                default:                      res_fix = a_neg_q ? (~rem + XLEN'(1)) : rem;
            endcase
        end

        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        fast_d     = fast_q;
        fast_val_d = fast_val_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        rq_d       = rq_q;
        result_d   = result_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !flush) begin
                    op_d       = op;
                    neg_d      = a_neg_in ^ b_neg_in;
                    a_neg_d    = a_neg_in;
                    fast_d     = is_fast;
                    fast_val_d = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : INT_MIN);
                    a_mag_d    = a_mag_in;
                    b_mag_d    = b_mag_in;
                    cnt_d      = '0;
                    prod_d     = {{XLEN{1'b0}}, b_mag_in};
                    rq_d       = {{(XLEN+1){1'b0}}, a_mag_in};
                    state_d    = is_fast ? FIX : CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[2]) begin
                    rq_d = div_diff[XLEN+1]
                         ? {div_shift[XLEN:0], rq_q[XLEN-2:0], 1'b0}
                         : {div_diff[XLEN:0],  rq_q[XLEN-2:0], 1'b1};
                end else begin
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN-1)) state_d = FIX;
            end
            FIX: begin
                result_d = res_fix;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            fast_q     <= 1'b0;
            fast_val_q <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            rq_q       <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            fast_q     <= fast_d;
            fast_val_q <= fast_val_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            rq_q       <= rq_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic
// reference model of the RV32M operations.
module tb_muldiv_sequencer;
    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int vectors = 0;
    int miscompares = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (o)
            3'd0: begin p = ux * uy;          r = p[31:0];  end
            3'd1: begin p = sx * sy;          r = p[63:32]; end
            3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
            3'd3: begin p = ux * uy;          r = p[63:32]; end
            3'd4: if (y == 0) r = 32'hFFFF_FFFF;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                  else r = 32'(sx / sy);
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: if (y == 0) r = x;
                  else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
                  else r = 32'(sx % sy);
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit div_op, signed_op;
        div_op    = (o >= 3'd4);
        signed_op = (o == 3'd4) || (o == 3'd6);
        if (div_op && (y == 0 || (signed_op && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Called at the negedge where start is presented; returns at the negedge of the done cycle.
    task automatic await_done(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat, busy_n, exp_lat;
        logic [31:0] exp;
        exp     = ref_result(o, x, y);
        exp_lat = ref_latency(o, x, y);
        lat     = 0;
        busy_n  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_n++;
        end while (!done && lat < 60);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, exp_lat - 1);
        check("result", result, exp);
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, x, y, result, exp, lat);
    endtask

    task automatic op_txn(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        launch(o, x, y);
        await_done(o, x, y);
        @(negedge clk);
        check("done_single_cycle", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        op_txn(3'd1, 32'hFFFF_FFFE, 32'd3);
        op_txn(3'd0, 32'hFFFF_FFFE, 32'd3);
        op_txn(3'd4, 32'hFFFF_FFF9, 32'd2);
        op_txn(3'd6, 32'hFFFF_FFF9, 32'd2);
        op_txn(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op_txn(3'd5, 32'd5, 32'd0);
        op_txn(3'd7, 32'd5, 32'd0);
        op_txn(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        op_txn(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        op_txn(3'd0, 32'd6, 32'd7);

        // Flush mid-divide with a simultaneous start: both must vanish.
        @(negedge clk);
        launch(3'd5, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        launch(3'd4, 32'd9, 32'd3);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_done", done, 1'b0);
        check("flush_result", result, 32'd42);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_start_dropped", {busy, done}, 2'b00);
        end
        $display("flush during DIVU 100/7: busy=%0b done=%0b result=%h", busy, done, result);

        // Back-to-back: the next start is presented in the DONE cycle.
        @(negedge clk);
        launch(3'd5, 32'd100, 32'd7);
        await_done(3'd5, 32'd100, 32'd7);
        launch(3'd0, 32'd6, 32'd7);
        await_done(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        check("b2b_done_single_cycle", done, 1'b0);

        // Reset in the middle of CALC.
        @(negedge clk);
        launch(3'd5, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 32'd0);
        $display("reset mid-CALC: busy=%0b done=%0b result=%h", busy, done, result);
        rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            op_txn(ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
